// File: rtl/muldiv_sequencer_if.sv
// Request/result bundle between the pipeline control and the MULT/DIV sequencer.
// Master: ControleALU, Start, A, B.
// Slave: Stall, Done, Hi, Lo, DivZero.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       ControleALU;
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Stall;
    logic             Done;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             DivZero;

    modport master (
        output ControleALU, Start, A, B,
        input  Stall, Done, Hi, Lo, DivZero
    );

    modport slave (
        input  ControleALU, Start, A, B,
        output Stall, Done, Hi, Lo, DivZero
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT (shift-add) / DIV (restoring) unit, one bit per cycle, Hi/Lo result.
// Latency: accept cycle + WIDTH busy cycles, Done pulse in cycle WIDTH+1; divide by zero: Done in cycle 1.
// Backpressure: Stall holds the pipeline from the accept cycle through BUSY; Start is ignored unless IDLE.
// Ports: clock, reset (sync, active high); bus.slave carries ControleALU/Start/A/B in and
// Stall/Done/Hi/Lo/DivZero out. Define MULDIV_SIGNED_EN for two's-complement operands.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                clock,
    input  logic                reset,
    muldiv_sequencer_if.slave   bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             isDiv;
    logic [WIDTH-1:0] operand;   // MULT: multiplicand, DIV: divisor
    logic [WIDTH-1:0] acc;       // MULT: product high half, DIV: partial remainder
    logic [WIDTH-1:0] low;       // MULT: multiplier/product low half, DIV: dividend/quotient
    logic [WIDTH-1:0] hiReg;
    logic [WIDTH-1:0] loReg;
    logic             doneReg;
    logic             divZeroReg;

    logic             validOp;
    logic             accept;
    logic [WIDTH-1:0] aMag;
    logic [WIDTH-1:0] bMag;

    assign validOp   = (bus.ControleALU == OP_MULT) || (bus.ControleALU == OP_DIV);
    assign accept    = (state == IDLE) && bus.Start && validOp;
    assign bus.Stall = accept || (state == BUSY);
    assign bus.Done  = doneReg;
    assign bus.Hi    = hiReg;
    assign bus.Lo    = loReg;
    assign bus.DivZero = divZeroReg;

`ifdef MULDIV_SIGNED_EN
    logic prodNeg;   // sign of product / quotient
    logic remNeg;    // sign of remainder follows the dividend

    always_comb begin
        aMag = bus.A[WIDTH-1] ? -bus.A : bus.A;
        bMag = bus.B[WIDTH-1] ? -bus.B : bus.B;
    end
`else
    always_comb begin
        aMag = bus.A;
        bMag = bus.B;
    end
`endif

    // One iteration step for each operation, plus the final result fix-up.
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   shRem;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] nextAcc;
    logic [WIDTH-1:0] nextLow;
    logic [WIDTH-1:0] resHi;
    logic [WIDTH-1:0] resLo;

    always_comb begin
        addend = low[0] ? operand : {WIDTH{1'b0}};
        sum    = {1'b0, acc} + {1'b0, addend};
        shRem  = {acc, low[WIDTH-1]};
        trial  = shRem - {1'b0, operand};
        // Remainder stays below the divisor, so a set MSB means the subtraction went negative.
        fits   = ~trial[WIDTH];
        if (isDiv) begin
            nextAcc = fits ? trial[WIDTH-1:0] : shRem[WIDTH-1:0];
            nextLow = {low[WIDTH-2:0], fits};
        end else begin
            nextAcc = sum[WIDTH:1];
            nextLow = {sum[0], low[WIDTH-1:1]};
        end
    end

`ifdef MULDIV_SIGNED_EN
    logic [2*WIDTH-1:0] prod;
    always_comb begin
        prod  = {nextAcc, nextLow};
        resHi = nextAcc;
        resLo = nextLow;
        if (isDiv) begin
            if (prodNeg) resLo = -nextLow;
            if (remNeg)  resHi = -nextAcc;
        end else if (prodNeg) begin
            prod  = -prod;
            resHi = prod[2*WIDTH-1:WIDTH];
            resLo = prod[WIDTH-1:0];
        end
    end
`else
    always_comb begin
        resHi = nextAcc;
        resLo = nextLow;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            isDiv      <= 1'b0;
            operand    <= '0;
            acc        <= '0;
            low        <= '0;
            hiReg      <= '0;
            loReg      <= '0;
            doneReg    <= 1'b0;
            divZeroReg <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            prodNeg    <= 1'b0;
            remNeg     <= 1'b0;
`endif
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        isDiv      <= (bus.ControleALU == OP_DIV);
                        count      <= '0;
                        acc        <= '0;
                        divZeroReg <= 1'b0;
`ifdef MULDIV_SIGNED_EN
                        prodNeg    <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                        remNeg     <= bus.A[WIDTH-1];
`endif
                        if (bus.ControleALU == OP_DIV) begin
                            operand <= bMag;
                            low     <= aMag;
                        end else begin
                            operand <= aMag;
                            low     <= bMag;
                        end
                        // Divide by zero bypasses iteration and reports straight away.
                        if ((bus.ControleALU == OP_DIV) && (bus.B == '0)) begin
                            hiReg      <= bus.A;
                            loReg      <= '1;
                            divZeroReg <= 1'b1;
                            doneReg    <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc <= nextAcc;
                    low <= nextLow;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        hiReg   <= resHi;
                        loReg   <= resLo;
                        doneReg <= 1'b1;
                        state   <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
    localparam int WIDTH = 32;
    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    muldiv_sequencer_if #(.WIDTH(WIDTH)) bus ();

    muldiv_sequencer #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on the operands as numbers.
    task automatic model(input bit isDiv, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        logic [63:0] p;
`ifdef MULDIV_SIGNED_EN
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
`endif
        dz = 1'b0;
        if (isDiv && b == 32'd0) begin
            hi = a;
            lo = 32'hFFFFFFFF;
            dz = 1'b1;
        end else if (isDiv) begin
`ifdef MULDIV_SIGNED_EN
            lo = 32'(sa / sb);
            hi = 32'(sa % sb);
`else
            lo = a / b;
            hi = a % b;
`endif
        end else begin
`ifdef MULDIV_SIGNED_EN
            p = 64'(sa * sb);
`else
            p = {32'd0, a} * {32'd0, b};
`endif
            hi = p[63:32];
            lo = p[31:0];
        end
    endtask

    task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag, input bit interfere);
        logic [31:0] eHi;
        logic [31:0] eLo;
        logic        eDz;
        int          cyc;
        int          expLat;
        bit          stallOk;
        model(op == OP_DIV, a, b, eHi, eLo, eDz);
        expLat = (op == OP_DIV && b == 32'd0) ? 1 : WIDTH + 1;
        @(posedge clock); #1;
        bus.ControleALU = op; bus.Start = 1'b1; bus.A = a; bus.B = b;
        #1;
        check({tag, " acceptStall"}, 64'(bus.Stall), 64'd1);
        @(posedge clock); #1;
        // Scramble inputs: results must come from the latched operands.
        bus.Start = 1'b0; bus.A = $urandom; bus.B = $urandom;
        cyc = 1;
        stallOk = 1'b1;
        while (!bus.Done && cyc < 100) begin
            if (!bus.Stall) stallOk = 1'b0;
            if (interfere && cyc == 5) begin
                bus.Start = 1'b1; bus.ControleALU = OP_MULT;
                bus.A = 32'd1234; bus.B = 32'd5678;
            end
            if (interfere && cyc == 6) bus.Start = 1'b0;
            @(posedge clock); #1;
            cyc++;
        end
        check({tag, " done"},      64'(bus.Done),    64'd1);
        check({tag, " latency"},   64'(cyc),         64'(expLat));
        check({tag, " busyStall"}, 64'(stallOk),     64'd1);
        check({tag, " doneStall"}, 64'(bus.Stall),   64'd0);
        check({tag, " Hi"},        64'(bus.Hi),      64'(eHi));
        check({tag, " Lo"},        64'(bus.Lo),      64'(eLo));
        check({tag, " DivZero"},   64'(bus.DivZero), 64'(eDz));
        // A valid Start held in the DONE cycle must not launch a new operation.
        if (interfere) begin
            bus.Start = 1'b1; bus.ControleALU = OP_MULT; bus.A = 32'd3; bus.B = 32'd3;
        end
        @(posedge clock); #1;
        bus.Start = 1'b0;
        #1;
        check({tag, " donePulse"}, 64'(bus.Done),  64'd0);
        check({tag, " idleStall"}, 64'(bus.Stall), 64'd0);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] ra;
        logic [31:0] rb;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.ControleALU = 4'd0; bus.Start = 1'b0; bus.A = '0; bus.B = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset Stall",   64'(bus.Stall),   64'd0);
        check("reset Done",    64'(bus.Done),    64'd0);
        check("reset Hi",      64'(bus.Hi),      64'd0);
        check("reset Lo",      64'(bus.Lo),      64'd0);
        check("reset DivZero", 64'(bus.DivZero), 64'd0);
        reset = 1'b0;

        runOp(OP_MULT, 32'd7, 32'd6, "mult7x6", 1'b0);
        check("mult7x6 Lo literal", 64'(bus.Lo), 64'd42);
        runOp(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, "multOnes", 1'b0);
        runOp(OP_DIV, 32'd100, 32'd7, "div100by7", 1'b0);
        runOp(OP_DIV, -32'sd100, 32'd7, "divNeg100by7", 1'b0);
        runOp(OP_DIV, 32'd5, 32'd0, "div5by0", 1'b0);
        runOp(OP_DIV, 32'h80000000, 32'hFFFFFFFF, "divMinByNeg1", 1'b0);
        runOp(OP_DIV, 32'd1000, 32'd33, "divInterfere", 1'b1);

        // Unsupported control code: no stall, no operation.
        @(posedge clock); #1;
        bus.ControleALU = 4'b0010; bus.Start = 1'b1; bus.A = 32'd9; bus.B = 32'd9;
        #1;
        check("badOp acceptStall", 64'(bus.Stall), 64'd0);
        @(posedge clock); #1;
        check("badOp nextStall", 64'(bus.Stall), 64'd0);
        check("badOp Done",      64'(bus.Done),  64'd0);
        bus.Start = 1'b0;

        // Reset in the middle of a multiply.
        @(posedge clock); #1;
        bus.ControleALU = OP_MULT; bus.Start = 1'b1; bus.A = 32'hDEADBEEF; bus.B = 32'h12345;
        @(posedge clock); #1;
        bus.Start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("midReset Stall",   64'(bus.Stall),   64'd0);
        check("midReset Done",    64'(bus.Done),    64'd0);
        check("midReset Hi",      64'(bus.Hi),      64'd0);
        check("midReset Lo",      64'(bus.Lo),      64'd0);
        check("midReset DivZero", 64'(bus.DivZero), 64'd0);
        runOp(OP_MULT, 32'd3, 32'd4, "mult3x4", 1'b0);

        for (int i = 0; i < 24; i++) begin
            op = ($urandom_range(0, 1) == 0) ? OP_MULT : OP_DIV;
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2, 3: rb = $urandom_range(1, 1000);
                default: rb = $urandom;
            endcase
            runOp(op, ra, rb, $sformatf("rand%0d", i), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the MULT (ALU control 4'b1000) and DIV (4'b1001) operations of the processor datapath. The single-cycle ALU cannot complete these operations in one cycle, so this block runs them iteratively over 32 cycles, one bit per cycle. It stalls the pipeline while busy and returns a 64-bit result split into Hi and Lo registers. It sits beside the ALU, is driven by the same ALU-control code, and releases the stall with a one-cycle done pulse.

## Interface
Parameters:
- WIDTH, 32, operand width. The iteration count equals WIDTH.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ControleALU  input  4  ALU control code. 4'b1000 = MULT, 4'b1001 = DIV. Any other code is not an operation for this block.
- Start  input  1  operation request, qualified by ControleALU.
- A  input  WIDTH  multiplicand or dividend.
- B  input  WIDTH  multiplier or divisor.
- Stall  output  1  pipeline hold request.
- Done  output  1  one-cycle pulse; Hi and Lo are valid.
- Hi  output  WIDTH  MULT: product[63:32]. DIV: remainder.
- Lo  output  WIDTH  MULT: product[31:0]. DIV: quotient.
- DivZero  output  1  the last DIV had B == 0; held until the next accepted start.

## Operation
- States:
  - IDLE: no operation in progress.
  - BUSY: iterative multiply or divide in progress.
  - DONE: result presented for one cycle.
- Accept condition: IDLE, Start = 1, and ControleALU is MULT or DIV. On accept, latch the op, A and B; clear the counter, the accumulators and DivZero; go to BUSY.
- Start with any other ControleALU code: ignored. No stall, no state change.
- Start outside IDLE: ignored. The latched operands are unaffected.
- MULT, shift-add: each BUSY cycle, if the multiplier LSB is 1, add the multiplicand into the upper accumulator half. Then shift the {acc, multiplier} pair right by 1, capturing the carry. Result after WIDTH cycles: {Hi, Lo} = A × B (2·WIDTH-bit product, never truncated).
- DIV, restoring: each BUSY cycle, shift {rem, quot} left by 1 and trial-subtract B from rem. If the result is non-negative, keep it and set the quotient LSB; otherwise restore.
- Division by zero: on accept with DIV and B == 0, skip BUSY and go directly to DONE next cycle with Lo = all ones, Hi = A, DivZero = 1.
- BUSY → DONE when the counter reaches WIDTH−1 (WIDTH iterations). DONE → IDLE unconditionally after one cycle.
- Hi and Lo update only on the transition into DONE, and hold until the next DONE or reset.

## Timing
- Reset values: state IDLE, Stall 0, Done 0, Hi 0, Lo 0, DivZero 0, counter 0.
- Reset mid-operation: the next edge forces IDLE and all reset values. The partial result is discarded and the stall is released.
- Stall is combinational and asserts in the accept cycle itself (IDLE, Start, valid op), so the instruction holds. It stays 1 throughout BUSY and is 0 in DONE.
- Latency: accept at edge 0; BUSY cycles 1..WIDTH; Done = 1 in cycle WIDTH+1, registered. Results are readable in that cycle, and the pipeline advances at the end of it.
- Division by zero: Done in cycle 1, i.e. a 2-cycle total stall including the accept cycle.
- Back-to-back: a Start held high in the DONE cycle is ignored. The next request is accepted in the following IDLE cycle at the earliest.
- Counter width: clog2(WIDTH) bits; no wrap beyond WIDTH−1.

## Configuration
- MULDIV_SIGNED_EN defined:
  - Operands are two's complement. Iterate on magnitudes, then fix signs.
  - Product sign = A[msb] ^ B[msb].
  - Quotient sign = A[msb] ^ B[msb]; remainder sign = A[msb].
  - −2^31 / −1 gives Lo = 32'h80000000, Hi = 0.
  - Sign fix-up is combinational on the DONE transition; latency is unchanged.
- MULDIV_SIGNED_EN undefined: all operands and results are unsigned. Sign logic is absent.

## Test plan
- MULT with A = 32'd7, B = 32'd6: Stall high cycles 0..32, Done at cycle 33, Hi = 0, Lo = 42.
- MULT with A = B = 32'hFFFFFFFF, unsigned: Hi = 32'hFFFFFFFE, Lo = 32'h00000001. With MULDIV_SIGNED_EN: Hi = 0, Lo = 1.
- DIV with A = 100, B = 7: Lo = 14, Hi = 2, DivZero = 0. With MULDIV_SIGNED_EN and A = −100: Lo = −14, Hi = −2.
- DIV with A = 5, B = 0: Done at cycle 1, Lo = 32'hFFFFFFFF, Hi = 5, DivZero = 1.
- Start with ControleALU = 4'b0010 → Stall stays 0 and state stays IDLE. A second Start during BUSY → ignored, first result correct.
- Reset asserted at BUSY cycle 10 → next cycle IDLE, Stall 0, Hi = Lo = 0. A subsequent MULT 3 × 4 gives Lo = 12.
